// File: rtl/clock_pkg.sv
// Shared types and constants for the mm:ss time-keeping core and the display stage.
// Holds the FSM state type, BCD limits, blink encodings and the mod-60 BCD increment.
package clock_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } state_t;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] ONES_MAX = 4'd9;

    localparam logic [1:0] BLINK_NONE = 2'b00;
    localparam logic [1:0] BLINK_SEC  = 2'b01;
    localparam logic [1:0] BLINK_MIN  = 2'b10;

    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd60_t;

    typedef struct packed {
        logic   carry;
        bcd60_t value;
    } bcd60_inc_t;

    // Out-of-range digits are treated as wrap points so a corrupted value self-heals.
    function automatic bcd60_inc_t bcd60_inc(input bcd60_t v);
        bcd60_inc_t r;
        r.carry = 1'b0;
        r.value = v;
        if (v.ones >= ONES_MAX) begin
            r.value.ones = '0;
            if (v.tens >= TENS_MAX) begin
                r.value.tens = '0;
                r.carry      = 1'b1;
            end else begin
                r.value.tens = v.tens + 4'd1;
            end
        end else begin
            r.value.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic logic [1:0] blink_of(input state_t s);
        logic [1:0] b;
        b = BLINK_NONE;
        if (s == SET_MIN) b = BLINK_MIN;
        if (s == SET_SEC) b = BLINK_SEC;
        return b;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous, debounced button followed by a
// single-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            prev <= sync[1];
        end
    end

    assign rise = sync[1] & ~prev;

endmodule

// File: rtl/mmss_time_counter.sv
// Minutes:seconds time-keeping core: 1 Hz prescaler, run/stop/set mode FSM and
// four BCD digit registers feeding the 7-segment display stage.
//
// state   | meaning
// STOP    | time frozen, prescaler held at 0
// RUN     | prescaler counting, digits advance once per TICK_DIV cycles
// SET_MIN | inc button steps minutes (mod 60), blink = minutes
// SET_SEC | inc button steps seconds (mod 60, no carry), blink = seconds
module mmss_time_counter
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_clr,
    output logic [15:0] digits,
    output logic [1:0]  blink,
    output logic        running,
    output logic        sec_tick,
    output logic        rollover
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    logic run_rise, mode_rise, inc_rise, clr_rise;

    btn_sync_edge u_sync_run  (.clock(clock), .reset(reset), .btn(btn_run),  .rise(run_rise));
    btn_sync_edge u_sync_mode (.clock(clock), .reset(reset), .btn(btn_mode), .rise(mode_rise));
    btn_sync_edge u_sync_inc  (.clock(clock), .reset(reset), .btn(btn_inc),  .rise(inc_rise));
    btn_sync_edge u_sync_clr  (.clock(clock), .reset(reset), .btn(btn_clr),  .rise(clr_rise));

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [15:0]   digits_nxt;
    logic          tick_nxt, roll_nxt;
    bcd60_inc_t    sec_inc, min_inc;

    always_comb begin
        state_nxt  = state;
        presc_nxt  = '0;
        digits_nxt = digits;
        tick_nxt   = 1'b0;
        roll_nxt   = 1'b0;
        sec_inc    = bcd60_inc(digits[7:0]);
        min_inc    = bcd60_inc(digits[15:8]);

        // Only the highest-priority edge acts: clr > run > mode > inc.
        if (clr_rise) begin
            digits_nxt = '0;
        end else if (run_rise) begin
            state_nxt = (state == RUN) ? STOP : RUN;
        end else begin
            case (state)
                STOP: begin
                    if (mode_rise) state_nxt = SET_MIN;
                end
                RUN: begin
                    if (presc == PRESC_LAST) begin
                        tick_nxt         = 1'b1;
                        digits_nxt[7:0]  = sec_inc.value;
                        if (sec_inc.carry) begin
                            digits_nxt[15:8] = min_inc.value;
                            roll_nxt         = min_inc.carry;
                        end
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
                SET_MIN: begin
                    if (mode_rise)     state_nxt = SET_SEC;
                    else if (inc_rise) digits_nxt[15:8] = min_inc.value;
                end
                SET_SEC: begin
                    if (mode_rise)     state_nxt = STOP;
                    else if (inc_rise) digits_nxt[7:0] = sec_inc.value;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= STOP;
            presc    <= '0;
            digits   <= '0;
            sec_tick <= 1'b0;
            rollover <= 1'b0;
            blink    <= BLINK_NONE;
            running  <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            digits   <= digits_nxt;
            sec_tick <= tick_nxt;
            rollover <= roll_nxt;
            blink    <= blink_of(state_nxt);
            running  <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_mmss_time_counter.sv
// Scoreboard bench for mmss_time_counter with TICK_DIV = 4: expected output
// vectors are queued when a button is driven and compared once it has acted.
module tb_mmss_time_counter;

    localparam int TD = 4;

    localparam logic [3:0] B_RUN  = 4'b1000;
    localparam logic [3:0] B_MODE = 4'b0100;
    localparam logic [3:0] B_INC  = 4'b0010;
    localparam logic [3:0] B_CLR  = 4'b0001;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        btn_run = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_clr = 1'b0;
    logic [15:0] digits;
    logic [1:0]  blink;
    logic        running, sec_tick, rollover;
    logic [20:0] obs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [20:0] val;
    } exp_t;

    exp_t sb[$];

    mmss_time_counter #(.TICK_DIV(TD)) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .btn_clr  (btn_clr),
        .digits   (digits),
        .blink    (blink),
        .running  (running),
        .sec_tick (sec_tick),
        .rollover (rollover)
    );

    always #5 clock = ~clock;

    assign obs = {digits, blink, running, sec_tick, rollover};

    function automatic logic [20:0] mk(logic [15:0] d, logic [1:0] b, logic r, logic t, logic ro);
        return {d, b, r, t, ro};
    endfunction

    function automatic logic [20:0] st(logic [15:0] d);
        return mk(d, 2'b00, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [20:0] rn(logic [15:0] d);
        return mk(d, 2'b00, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [7:0] bcd2(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(string tag, logic [20:0] act, logic [20:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got digits=%h blink=%b run=%b tick=%b roll=%b, expected digits=%h blink=%b run=%b tick=%b roll=%b",
                     tag, act[20:5], act[4:3], act[2], act[1], act[0],
                     exp[20:5], exp[4:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic push(string tag, logic [20:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic drive(logic [3:0] m);
        {btn_run, btn_mode, btn_inc, btn_clr} = m;
    endtask

    // Called on a falling edge; returns on the falling edge after the press has acted.
    task automatic press(logic [3:0] m, string tag, logic [20:0] v);
        drive(m);
        push(tag, v);
        @(negedge clock);
        drive(4'b0000);
        @(negedge clock);
        @(negedge clock);
        drain();
    endtask

    // Called on the falling edge after RUN entry or after the previous advance.
    task automatic run_tick(logic [15:0] prev, logic [15:0] nxt, logic ro, string tag);
        for (int i = 1; i < TD; i++) begin
            push(tag, rn(prev));
            @(negedge clock);
            drain();
        end
        push(tag, mk(nxt, 2'b00, 1'b1, 1'b1, ro));
        @(negedge clock);
        drain();
    endtask

    task automatic preload(int mm, int ss);
        press(B_CLR, "pre_clr", st(16'h0000));
        press(B_MODE, "pre_min", mk(16'h0000, 2'b10, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i <= mm; i++)
            press(B_INC, "pre_inc_min", mk({bcd2(i), 8'h00}, 2'b10, 1'b0, 1'b0, 1'b0));
        press(B_MODE, "pre_sec", mk({bcd2(mm), 8'h00}, 2'b01, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i <= ss; i++)
            press(B_INC, "pre_inc_sec", mk({bcd2(mm), bcd2(i)}, 2'b01, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        repeat (2) @(negedge clock);
        push("reset_hold", st(16'h0000));
        drain();
        reset = 1'b1;
        @(negedge clock);
        push("reset_release", st(16'h0000));
        drain();

        // Start, first advance, stop with prescaler at its last count.
        press(B_RUN, "run_start", rn(16'h0000));
        run_tick(16'h0000, 16'h0001, 1'b0, "first_tick");
        push("tick_pulse_end", rn(16'h0001));
        @(negedge clock);
        drain();
        press(B_RUN, "stop_at_last", st(16'h0001));
        repeat (3) @(negedge clock);
        push("stopped_hold", st(16'h0001));
        drain();
        press(B_RUN, "restart", rn(16'h0001));
        run_tick(16'h0001, 16'h0002, 1'b0, "restart_full_period");
        press(B_RUN, "stop2", st(16'h0002));

        // Held button: exactly one toggle, four advances in the window.
        drive(B_RUN);
        repeat (20) @(negedge clock);
        drive(4'b0000);
        @(negedge clock);
        push("hold_one_toggle", rn(16'h0006));
        drain();
        press(B_RUN, "stop3", st(16'h0007));
        press(B_CLR, "clr_stop", st(16'h0000));

        // Set mode wrap behaviour.
        press(B_MODE, "set_min", mk(16'h0000, 2'b10, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i <= 61; i++)
            press(B_INC, "inc_min", mk({bcd2(i % 60), 8'h00}, 2'b10, 1'b0, 1'b0, 1'b0));
        press(B_MODE, "set_sec", mk(16'h0100, 2'b01, 1'b0, 1'b0, 1'b0));
        for (int i = 1; i <= 60; i++)
            press(B_INC, "inc_sec", mk({8'h01, bcd2(i % 60)}, 2'b01, 1'b0, 1'b0, 1'b0));
        press(B_MODE, "set_exit", st(16'h0100));

        // Seconds-ones carry into tens.
        preload(0, 9);
        press(B_RUN, "run_0009", rn(16'h0009));
        run_tick(16'h0009, 16'h0010, 1'b0, "sec_carry");
        press(B_RUN, "stop4", st(16'h0010));

        // Full rollover.
        preload(59, 59);
        press(B_RUN, "run_5959", rn(16'h5959));
        run_tick(16'h5959, 16'h0000, 1'b1, "rollover");
        push("rollover_end", rn(16'h0000));
        @(negedge clock);
        drain();
        press(B_RUN, "stop5", st(16'h0000));

        // Simultaneous edges from STOP: run wins.
        press(B_RUN | B_MODE | B_INC, "simul_edges", rn(16'h0000));
        for (int k = 0; k < 5; k++)
            run_tick({8'h00, bcd2(k)}, {8'h00, bcd2(k + 1)}, 1'b0, "run_count");
        @(negedge clock);
        push("pre_clr_tick", rn(16'h0005));
        drain();
        drive(B_CLR);
        @(negedge clock);
        drive(4'b0000);
        @(negedge clock);
        push("clr_pending", rn(16'h0005));
        drain();
        @(negedge clock);
        push("clr_vs_tick", rn(16'h0000));
        drain();
        run_tick(16'h0000, 16'h0001, 1'b0, "post_clr_period");
        press(B_RUN, "stop6", st(16'h0001));

        // Asynchronous reset while running at 12:34.
        preload(12, 34);
        press(B_RUN, "run_1234", rn(16'h1234));
        @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        push("async_reset", st(16'h0000));
        drain();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        push("after_reset", st(16'h0000));
        drain();
        drive(B_RUN);
        @(negedge clock);
        drive(4'b0000);
        push("latency_n", st(16'h0000));
        drain();
        @(negedge clock);
        push("latency_n1", st(16'h0000));
        drain();
        @(negedge clock);
        push("latency_n2", rn(16'h0000));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmss_time_counter.md
# mmss_time_counter

Minutes:seconds time-keeping core for the board digital clock. It sits directly upstream of the 7-segment scan/decode stage, which drives AN/C. It owns the 1 Hz prescaler, the run/stop/set mode FSM and four BCD digit registers. The display stage consumes the digits and a blink mask.

## Interface
- TICK_DIV, 100_000_000: clock cycles per second tick. Minimum 2; set to 4 in simulation.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset values below.
- btn_run  input  1  start/stop button, already debounced, asynchronous to clock.
- btn_mode  input  1  set-mode step button, already debounced, asynchronous.
- btn_inc  input  1  increment-field button, already debounced, asynchronous.
- btn_clr  input  1  clear-time button, already debounced, asynchronous.
- digits  output  16  BCD digits {min_tens, min_ones, sec_tens, sec_ones}, registered.
- blink  output  2  field under adjustment: 2'b10 = minutes, 2'b01 = seconds, 2'b00 = none.
- running  output  1  1 while the FSM is in RUN.
- sec_tick  output  1  one-cycle pulse when seconds advance in RUN.
- rollover  output  1  one-cycle pulse when 59:59 advances to 00:00 in RUN.

## Operation
- Each button passes through a 2-FF synchronizer, then a rising-edge detector. Only the 0→1 edge acts; holding a button has no further effect.
- FSM states: STOP (reset state), RUN, SET_MIN, SET_SEC.
  - STOP: run edge → RUN; mode edge → SET_MIN.
  - RUN: run edge → STOP; mode and inc edges are ignored.
  - SET_MIN: inc edge → minutes +1 mod 60; mode edge → SET_SEC; run edge → RUN.
  - SET_SEC: inc edge → seconds +1 mod 60, with no carry into minutes; mode edge → STOP; run edge → RUN.
- Edges arriving in the same cycle have this priority: clr > run > mode > inc. Only the highest-priority edge acts.
- clr edge, in any state: digits → 0000 and prescaler → 0. The FSM state is unchanged. A clr in the same cycle as a tick wins, and no sec_tick is produced.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - Forced to 0 in every other state, so a stop/start restarts the full second.
  - At TICK_DIV-1 it wraps to 0 and advances time by one second.
- BCD arithmetic, all digits 4 bits:
  - sec_ones wraps 9→0 and carries into sec_tens.
  - sec_tens wraps 5→0 and carries into min_ones.
  - min_ones wraps 9→0 and carries into min_tens.
  - min_tens wraps 5→0.
  - 59:59 → 00:00 asserts rollover together with sec_tick.
- Digit values above their legal range are unreachable. The increment logic treats them as wrap points anyway: any value ≥9 for ones digits, ≥5 for tens digits.
- blink = 2'b10 in SET_MIN, 2'b01 in SET_SEC, 2'b00 otherwise. running = 1 only in RUN.

## Timing
- Reset values: digits = 16'h0000, blink = 00, running = 0, sec_tick = 0, rollover = 0, FSM = STOP, prescaler = 0, synchronizer flops = 0.
- Button latency: a button first sampled high at edge n acts at edge n+2. The new state/digits are visible on outputs after edge n+2.
- RUN start: if the FSM becomes RUN at edge m, the first second advance happens at edge m+TICK_DIV. After that, one advance every TICK_DIV cycles.
- sec_tick and rollover are registered. They are high for exactly the cycle following the advancing edge, coincident with the new digits.
- Stop: the FSM leaves RUN at edge s. No advance occurs at s or later, even if the prescaler was at TICK_DIV-1 at edge s; the run edge wins.
- A reset assertion mid-count clears everything immediately. The first run edge after release needs the full 2-edge synchronizer latency.

## Structure
- Shared package clock_pkg holds:
  - the FSM state typedef (STOP, RUN, SET_MIN, SET_SEC);
  - the BCD digit width (4);
  - constants TENS_MAX = 5 and ONES_MAX = 9;
  - the blink encodings.
- The display stage imports the same blink encodings.
- One sub-module: btn_sync_edge, a 2-FF synchronizer plus a one-cycle rising-edge pulse with async active-low reset. It is instantiated four times.
- The mod-60 BCD increment is a package function, used both for the tick path and for set-mode increments.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset → outputs: digits 0000, blink 00, running 0, no pulses. btn_run held high 1 cycle → running = 1 two edges later, then the first sec_tick 4 cycles after entry and digits = 0001.
- Preload 00:09 via set mode, then run → after one tick, digits = 0010. Preload 59:59, then run → next tick gives digits = 0000 with sec_tick and rollover high for 1 cycle.
- Set mode:
  - mode → blink = 10; inc ×61 → minutes = 01.
  - mode → blink = 01; inc ×60 → seconds = 00, minutes still 01.
  - mode → blink = 00, state STOP, running = 0.
- Simultaneous edges: run + mode + inc rising in the same cycle from STOP → RUN only, digits unchanged. clr coinciding with a tick at 00:05 → 0000, no sec_tick.
- Stop/restart: stop when the prescaler is at 3 → no advance. Restart → the advance comes a full 4 cycles later. Holding btn_run high for 20 cycles → exactly one toggle.
- Reset asserted asynchronously (mid-cycle) while running at 12:34 → outputs return to reset values immediately, without waiting for a clock edge.
